// File: rtl/arb_pkg.sv
// Shared constants and helpers for the N-client hold arbiter.
package arb_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // OR-reduction of set-bit indices; exact for one-hot or zero input.
  function automatic int unsigned oh2idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority or rotating priority from ptr.
module arb_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   cand,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id,
  output logic           any
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;
  int             sel;

  always_comb begin
    // Fixed mode leaves the lower half empty, so the plain vector in the upper half decides.
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (mode == ARB_RR) && (i >= 32'(ptr));
    end
    dbl = {cand, cand & hi_mask};
    sel = 0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) sel = i;
    end
    if (sel >= int'(N)) sel = sel - int'(N);
    any    = |cand;
    win    = any ? (N'(1) << sel) : '0;
    win_id = IDW'(sel);
  end

endmodule

// File: rtl/arbiter_rr_hold.sv
// N-client arbiter with registered one-hot grant, hold-until-release and optional hold limit.
module arbiter_rr_hold
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 0,
  localparam int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           valid_q;
  logic           preempt_q, preempt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic [N-1:0]   cand, others, win;
  logic [IDW-1:0] win_id;
  logic           any, owner_req, at_limit, grant_new;

  assign others    = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);
  assign at_limit  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign cand      = (state_q == ARB_IDLE) ? req : others;

  arb_pick #(
    .N(N)
  ) u_pick (
    .cand  (cand),
    .ptr   (ptr_q),
    .mode  (mode),
    .win   (win),
    .win_id(win_id),
    .any   (any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    grant_new = 1'b0;
    case (state_q)
      ARB_IDLE: grant_new = any;
      ARB_BUSY: begin
        // Release takes precedence over the hold limit, so no preempt pulse on release.
        if (!owner_req) begin
          if (any) begin
            grant_new = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (at_limit && any) begin
          grant_new = 1'b1;
          preempt_d = 1'b1;
        end else if ((MAX_HOLD != 0) && !at_limit) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (grant_new) begin
      state_d = ARB_BUSY;
      gnt_d   = win;
      hold_d  = '0;
      ptr_d   = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      valid_q   <= |gnt_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;
  assign gnt_id    = IDW'(oh2idx(32'(gnt_q)));

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random vs. model.
module tb_arbiter_rr_hold;

  localparam int N   = 4;
  localparam int MH  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  always #5 clk = ~clk;

  arbiter_rr_hold #(
    .N       (N),
    .MAX_HOLD(MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .preempt  (preempt)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: owner index (-1 idle), rotation pointer, cycles owned so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_pre   = 1'b0;

  function automatic int pick(input logic [N-1:0] c, input bit rr, input int p);
    int start;
    int idx;
    start = rr ? p : 0;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (c[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] c;
    int w;
    w = -1;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_pre   = 1'b0;
      return;
    end
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (req != 0) w = pick(req, mode, m_ptr);
    end else begin
      c = req;
      c[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        if (c != 0) w = pick(c, mode, m_ptr);
        else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end else if (MH != 0 && m_hold == MH - 1 && c != 0) begin
        w = pick(c, mode, m_ptr);
        m_pre = 1'b1;
      end else if (MH != 0 && m_hold < MH - 1) begin
        m_hold++;
      end
    end
    if (w >= 0) begin
      m_owner = w;
      m_hold  = 0;
      m_ptr   = (w + 1) % N;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the inputs as driven, then compare after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, " gnt"}, 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, " gnt_valid"}, 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check({tag, " gnt_id"}, 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, " preempt"}, 32'(preempt), 32'(m_pre));
    check({tag, " onehot0"}, 32'($onehot0(gnt)), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       mode;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       pre;
  } vec_t;

  vec_t tbl[19];

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    req  = '0;

    // Reset with requests, fixed priority, no-bubble handoff.
    tbl[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0};
    // Round-robin rotation with each owner releasing once.
    tbl[6]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'b1110, 4'b0010, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'b1101, 4'b0100, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'b1011, 4'b1000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0};
    // Hold limit: owner 2 for four cycles, then forced handoff to 0.
    tbl[12] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'b0101, 4'b0100, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 4'b0101, 4'b0100, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 1'b0};

    for (int i = 0; i < 19; i++) begin
      rst  = tbl[i].rst;
      mode = tbl[i].mode;
      req  = tbl[i].req;
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d exp_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d exp_preempt", i), 32'(preempt), 32'(tbl[i].pre));
    end

    // Sole requester past the hold limit: never preempted.
    rst = 1'b1;
    req = '0;
    tick("solo_rst");
    rst  = 1'b0;
    mode = 1'b1;
    req  = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      tick($sformatf("solo%0d", i));
      check("solo gnt", 32'(gnt), 32'h8);
      check("solo preempt", 32'(preempt), 32'h0);
    end

    // Reset while busy clears grant and pointer.
    rst = 1'b1;
    req = '0;
    tick("busyrst_pre");
    rst  = 1'b0;
    mode = 1'b1;
    req  = 4'b0100;
    tick("busyrst_own");
    req = 4'b0110;
    tick("busyrst_hold");
    check("busyrst owner2", 32'(gnt), 32'h4);
    rst = 1'b1;
    tick("busyrst_rst");
    check("busyrst cleared", 32'(gnt), 32'h0);
    rst = 1'b0;
    tick("busyrst_rearb");
    check("busyrst regrant", 32'(gnt), 32'h2);

    // Random traffic: sticky requests, occasional mode changes and resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ((i % 25) == 0) mode = 1'($urandom_range(0, 1));
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      tick($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
